// File: rtl/dp_mem_responder.sv
// dp_mem_responder
//   Stands in for the cache level between the datapath and a single-port RAM.
//   Instruction fetches and data reads/writes are serialized onto the RAM one
//   transaction at a time. Data requests win over fetches. Once the datapath
//   raises halt, new fetches are no longer accepted.
//
// Ports
//   CLK, nRST              clock (rising edge), async active-low reset
//   imemREN, imemaddr      instruction fetch request / address
//   dmemREN, dmemWEN       data read / write request (both high = write)
//   dmemaddr, dmemstore    data address / write data
//   halt                   datapath halted (captured into sticky halted)
//   ihit, imemload         fetch complete pulse / fetched instruction
//   dhit, dmemload         data access complete pulse / loaded data
//   ramREN, ramWEN         RAM read / write strobes
//   ramaddr, ramstore      RAM address / write data (hold last captured value)
//   ramload, ramstate      RAM read data / status (0 FREE 1 BUSY 2 ACCESS 3 ERROR)
//   halted, err            sticky halt copy / sticky RAM error-or-timeout flag
//   dbg_state              current FSM state (0 IDLE 1 DREQ 2 IREQ 3 RESP)
//
// Handshake: a request is sampled only in IDLE. The matching hit is a single
// registered cycle decoded from RESP. A request still high in the cycle after
// its hit is taken as a new request, so the datapath drops it on the edge that
// ends the hit cycle.

module dp_mem_responder #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        halted,
    output logic        err,
    output logic [1:0]  dbg_state
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        IREQ = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          from_d;     // current/last transaction was a data access
    logic          wr_q;       // current transaction is a write
    logic [31:0]   addr_q;
    logic [31:0]   store_q;
    logic [CW-1:0] wait_cnt;

    logic in_req;
    logic ram_ok;
    logic ram_fail;
    logic d_req;
    logic i_req;

    assign in_req   = (state == DREQ) || (state == IREQ);
    assign ram_ok   = in_req && (ramstate == RAM_ACCESS);
    // ACCESS wins if it lands on the same cycle as the timeout.
    assign ram_fail = in_req && !ram_ok &&
                      ((ramstate == RAM_ERROR) || (wait_cnt == LAST_WAIT));
    assign d_req    = dmemREN || dmemWEN;
    assign i_req    = imemREN && !halted;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_req) begin
                    next_state = DREQ;
                end else if (i_req) begin
                    next_state = IREQ;
                end
            end
            DREQ, IREQ: begin
                if (ram_ok || ram_fail) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: everything here is a function of registered state only.
    always_comb begin
        ramREN    = in_req && !wr_q;
        ramWEN    = in_req && wr_q;
        ihit      = (state == RESP) && !from_d;
        dhit      = (state == RESP) && from_d;
        dbg_state = state;
    end

    assign ramaddr  = addr_q;
    assign ramstore = store_q;

    // Transaction capture, load registers, wait counter and sticky flags
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            from_d   <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            store_q  <= '0;
            wait_cnt <= '0;
            imemload <= '0;
            dmemload <= '0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            halted <= halted | halt;

            if (state == IDLE) begin
                if (d_req) begin
                    addr_q   <= dmemaddr;
                    store_q  <= dmemstore;
                    wr_q     <= dmemWEN;
                    from_d   <= 1'b1;
                    wait_cnt <= '0;
                end else if (i_req) begin
                    // Fetches never write; ramstore keeps its last value.
                    addr_q   <= imemaddr;
                    wr_q     <= 1'b0;
                    from_d   <= 1'b0;
                    wait_cnt <= '0;
                end
            end

            if (ram_ok) begin
                if (!wr_q) begin
                    if (from_d) begin
                        dmemload <= ramload;
                    end else begin
                        imemload <= ramload;
                    end
                end
            end else if (ram_fail) begin
                err <= 1'b1;
                if (from_d) begin
                    dmemload <= ERR_WORD;
                end else begin
                    imemload <= ERR_WORD;
                end
            end else if (in_req) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Directed testbench for dp_mem_responder (TIMEOUT overridden to 8).
// A small behavioural RAM answers ACCESS after ram_lat strobe cycles, or
// stays BUSY (ram_hang), or answers ERROR (ram_err). Read data comes from a
// fixed address table. Inputs are driven and outputs checked 1 time unit
// after each rising edge; "cycle k" below is the cycle after the k-th edge
// counted from the edge that samples the request.

module tb_dp_mem_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        halt;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        halted;
    logic        err;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // RAM model controls
    int   ram_lat  = 0;
    logic ram_hang = 1'b0;
    logic ram_err  = 1'b0;
    int   ram_cnt;

    always #5 CLK = ~CLK;

    dp_mem_responder #(
        .TIMEOUT (8),
        .ERR_WORD(32'hBAD1BAD1)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .dmemREN  (dmemREN),
        .dmemWEN  (dmemWEN),
        .dmemaddr (dmemaddr),
        .dmemstore(dmemstore),
        .halt     (halt),
        .ihit     (ihit),
        .imemload (imemload),
        .dhit     (dhit),
        .dmemload (dmemload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .halted   (halted),
        .err      (err),
        .dbg_state(dbg_state)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: ram_word = 32'h8C22_0004;
            32'h0000_0044: ram_word = 32'h3C01_ABCD;
            32'h0000_0100: ram_word = 32'h1111_2222;
            32'h0000_0104: ram_word = 32'h3333_4444;
            default:       ram_word = 32'h0000_0000;
        endcase
    endfunction

    always_comb ramload = ram_word(ramaddr);

    // Counts strobe cycles of the current access.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ram_cnt <= 0;
        end else if (ramREN || ramWEN) begin
            ram_cnt <= ram_cnt + 1;
        end else begin
            ram_cnt <= 0;
        end
    end

    always_comb begin
        ramstate = 2'd0;
        if (ramREN || ramWEN) begin
            if (ram_err) begin
                ramstate = 2'd3;
            end else if (!ram_hang && (ram_cnt >= ram_lat)) begin
                ramstate = 2'd2;
            end else begin
                ramstate = 2'd1;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        nRST      = 1'b1;
        imemREN   = 1'b0;
        imemaddr  = '0;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        halt      = 1'b0;
        #2;
        nRST = 1'b0;
        step();
        step();

        // ---------------- Reset state ----------------
        check("rst_ihit",     ihit,     0);
        check("rst_dhit",     dhit,     0);
        check("rst_imemload", imemload, 0);
        check("rst_dmemload", dmemload, 0);
        check("rst_ramREN",   ramREN,   0);
        check("rst_ramWEN",   ramWEN,   0);
        check("rst_ramaddr",  ramaddr,  0);
        check("rst_ramstore", ramstore, 0);
        check("rst_halted",   halted,   0);
        check("rst_err",      err,      0);
        check("rst_state",    dbg_state, 0);
        nRST = 1'b1;
        step();

        // ---------------- Fetch, immediate ACCESS ----------------
        ram_lat  = 0;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        step();                                      // cycle 1
        check("f1_ramREN",  ramREN,  1);
        check("f1_ramWEN",  ramWEN,  0);
        check("f1_ramaddr", ramaddr, 32'h40);
        check("f1_ihit_c1", ihit,    0);
        step();                                      // cycle 2
        check("f1_ihit_c2", ihit,     1);
        check("f1_dhit_c2", dhit,     0);
        check("f1_imemld",  imemload, 32'h8C220004);
        check("f1_ramREN2", ramREN,   0);
        step();                                      // cycle 3
        imemREN = 1'b0;
        check("f1_ihit_c3", ihit,     0);
        check("f1_imemld3", imemload, 32'h8C220004);

        // ---------------- Data beats fetch, RAM BUSY 3 ----------------
        ram_lat  = 3;
        imemREN  = 1'b1;
        imemaddr = 32'h44;
        dmemREN  = 1'b1;
        dmemaddr = 32'h100;
        step();                                      // cycle 1
        check("pr_ramREN_c1",  ramREN,  1);
        check("pr_ramaddr_c1", ramaddr, 32'h100);
        step(); step(); step();                      // cycle 4
        check("pr_dhit_c4", dhit, 0);
        step();                                      // cycle 5
        check("pr_dhit_c5", dhit,     1);
        check("pr_ihit_c5", ihit,     0);
        check("pr_dmemld",  dmemload, 32'h11112222);
        dmemREN = 1'b0;
        step();                                      // cycle 6
        check("pr_ramREN_c6", ramREN, 0);
        check("pr_dhit_c6",   dhit,   0);
        step();                                      // cycle 7
        check("pr_ramREN_c7",  ramREN,  1);
        check("pr_ramaddr_c7", ramaddr, 32'h44);
        step(); step(); step();                      // cycle 10
        check("pr_ihit_c10", ihit, 0);
        step();                                      // cycle 11
        check("pr_ihit_c11", ihit,     1);
        check("pr_imemld",   imemload, 32'h3C01ABCD);
        imemREN = 1'b0;
        step();                                      // cycle 12
        check("pr_ihit_c12", ihit, 0);

        // ---------------- Write (REN and WEN both high) ----------------
        ram_lat   = 0;
        dmemREN   = 1'b1;
        dmemWEN   = 1'b1;
        dmemaddr  = 32'h200;
        dmemstore = 32'hDEADBEEF;
        step();                                      // cycle 1
        check("wr_ramWEN",   ramWEN,   1);
        check("wr_ramREN",   ramREN,   0);
        check("wr_ramaddr",  ramaddr,  32'h200);
        check("wr_ramstore", ramstore, 32'hDEADBEEF);
        step();                                      // cycle 2
        check("wr_dhit",   dhit,     1);
        check("wr_dmemld", dmemload, 32'h11112222);
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        step();                                      // cycle 3
        check("wr_dhit_c3",   dhit,     0);
        check("wr_ramWEN_c3", ramWEN,   0);
        check("wr_store_hold", ramstore, 32'hDEADBEEF);

        // ---------------- Timeout with RAM stuck BUSY ----------------
        ram_hang = 1'b1;
        dmemREN  = 1'b1;
        dmemaddr = 32'h100;
        step();                                      // cycle 1
        check("to_ramREN_c1", ramREN, 1);
        repeat (7) step();                           // cycle 8
        check("to_dhit_c8",   dhit,   0);
        check("to_err_c8",    err,    0);
        check("to_ramREN_c8", ramREN, 1);
        step();                                      // cycle 9
        check("to_dhit_c9",   dhit,     1);
        check("to_dmemld",    dmemload, 32'hBAD1BAD1);
        check("to_err_c9",    err,      1);
        check("to_ramREN_c9", ramREN,   0);
        dmemREN  = 1'b0;
        ram_hang = 1'b0;
        step();                                      // cycle 10
        check("to_err_sticky", err,  1);
        check("to_dhit_c10",   dhit, 0);

        // ---------------- Reset during DREQ ----------------
        ram_lat  = 3;
        dmemREN  = 1'b1;
        dmemaddr = 32'h100;
        step();                                      // cycle 1
        check("mr_ramREN_c1", ramREN, 1);
        step();                                      // cycle 2
        nRST = 1'b0;
        #1;
        check("mr_ramREN",   ramREN,   0);
        check("mr_dhit",     dhit,     0);
        check("mr_err",      err,      0);
        check("mr_dmemload", dmemload, 0);
        check("mr_imemload", imemload, 0);
        check("mr_ramaddr",  ramaddr,  0);
        check("mr_ramstore", ramstore, 0);
        dmemREN = 1'b0;
        step();
        step();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mr_no_dhit",   dhit,   0);
            check("mr_no_strobe", ramREN, 0);
        end
        ram_lat  = 0;
        dmemREN  = 1'b1;
        dmemaddr = 32'h104;
        step();                                      // cycle 1
        check("mr_resume_ren", ramREN, 1);
        step();                                      // cycle 2
        check("mr_resume_dhit", dhit,     1);
        check("mr_resume_ld",   dmemload, 32'h33334444);
        dmemREN = 1'b0;
        step();

        // ---------------- RAM ERROR on a fetch ----------------
        ram_err  = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        step();                                      // cycle 1
        check("er_ramREN", ramREN, 1);
        check("er_err_c1", err,    0);
        step();                                      // cycle 2
        check("er_ihit",   ihit,     1);
        check("er_imemld", imemload, 32'hBAD1BAD1);
        check("er_err_c2", err,      1);
        imemREN = 1'b0;
        ram_err = 1'b0;
        step();                                      // cycle 3
        check("er_err_sticky", err, 1);

        // ---------------- Halt during an in-flight fetch ----------------
        ram_lat  = 3;
        imemREN  = 1'b1;
        imemaddr = 32'h44;
        step();                                      // cycle 1
        check("ht_ramREN_c1", ramREN, 1);
        check("ht_halted_c1", halted, 0);
        halt = 1'b1;
        step();                                      // cycle 2
        halt = 1'b0;
        check("ht_halted_c2", halted, 1);
        step(); step();                              // cycle 4
        check("ht_ihit_c4", ihit, 0);
        step();                                      // cycle 5
        check("ht_ihit_c5", ihit,     1);
        check("ht_imemld",  imemload, 32'h3C01ABCD);
        for (int i = 0; i < 20; i++) begin
            step();
            check("ht_no_fetch_ren", ramREN, 0);
            check("ht_no_ihit",      ihit,   0);
        end
        dmemREN  = 1'b1;
        dmemaddr = 32'h100;
        step();                                      // cycle 1
        check("ht_d_ramREN",  ramREN,  1);
        check("ht_d_ramaddr", ramaddr, 32'h100);
        step(); step(); step();                      // cycle 4
        check("ht_d_dhit_c4", dhit, 0);
        step();                                      // cycle 5
        check("ht_d_dhit_c5", dhit,     1);
        check("ht_d_ihit_c5", ihit,     0);
        check("ht_d_dmemld",  dmemload, 32'h11112222);
        dmemREN = 1'b0;
        step();
        check("ht_end_ihit",   ihit,   0);
        check("ht_end_ramREN", ramREN, 0);
        check("ht_end_halted", halted, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
